// File: rtl/lsu_axi_pkg.sv
// Shared definitions for the load/store unit: widths, func3 codes, AXI response codes,
// FSM states and the store lane helpers.
package lsu_axi_pkg;

    localparam int CPU_Width = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4,
        S_OUT   = 3'd5
    } lsu_state_e;

    // Byte strobes; shifted half-word strobes fall off the top lane rather than wrapping.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    store_strb = 4'b0001 << off;
            F3_H:    store_strb = 4'b0011 << off;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [CPU_Width-1:0] store_data(input logic [2:0] f3,
                                                        input logic [CPU_Width-1:0] rs2);
        case (f3)
            F3_B:    store_data = {4{rs2[7:0]}};
            F3_H:    store_data = {2{rs2[15:0]}};
            default: store_data = rs2;
        endcase
    endfunction

endpackage

// File: rtl/lsu_axi_ld_ext.sv
// Load lane select and sign/zero extension: shifts the addressed byte lane down
// and extends it according to func3.
module lsu_ld_ext
    import lsu_axi_pkg::*;
(
    input  logic [CPU_Width-1:0] i_rdata,
    input  logic [1:0]           i_off,
    input  logic [2:0]           i_func3,
    output logic [CPU_Width-1:0] o_data
);

    logic [CPU_Width-1:0] w_shift;

    assign w_shift = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = w_shift;
        case (i_func3)
            F3_B:    o_data = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_data = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_BU:   o_data = {24'd0, w_shift[7:0]};
            F3_HU:   o_data = {16'd0, w_shift[15:0]};
            default: o_data = w_shift;
        endcase
    end

endmodule

// File: rtl/lsu_axi.sv
// Load/store unit: takes one EXU packet, performs it as a 32-bit AXI4-Lite master and
// presents the result to WBU. Optional misalignment trap: define LSU_MISALIGN_CHK_EN.
module lsu_axi
    import lsu_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = CPU_Width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pre_valid,
    output logic              o_pre_ready,
    output logic              o_post_valid,
    input  logic              i_post_ready,
    input  logic [DATA_W-1:0] i_lsu_alu_res,
    input  logic              i_lsu_is_load,
    input  logic              i_lsu_is_store,
    input  logic [2:0]        i_lsu_func3,
    input  logic [DATA_W-1:0] i_lsu_rs2,
    input  logic [4:0]        i_lsu_rd_id,
    input  logic              i_lsu_gpr_wen,
    output logic [DATA_W-1:0] o_lsu_wb_data,
    output logic [4:0]        o_lsu_rd_id,
    output logic              o_lsu_gpr_wen,
    output logic              o_lsu_bus_err,
    output logic              o_lsu_fault,
    output logic [2:0]        o_dbg_state,
    output logic [ADDR_W-1:0] o_araddr,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rvalid,
    output logic              o_rready,
    output logic [ADDR_W-1:0] o_awaddr,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [DATA_W-1:0] o_wdata,
    output logic [3:0]        o_wstrb,
    output logic              o_wvalid,
    input  logic              i_wready,
    input  logic [1:0]        i_bresp,
    input  logic              i_bvalid,
    output logic              o_bready
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; every valid
    // here is a register that, once raised, holds with stable payload until that edge.
    lsu_state_e        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_func3;
    logic [4:0]        r_rd_id;
    logic              r_gpr_wen;
    logic [DATA_W-1:0] r_wb_data;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_bus_err;
    logic              r_post_valid;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              w_misalign;
    logic              w_aw_done;
    logic              w_w_done;
    logic [DATA_W-1:0] w_ld_data;

`ifdef LSU_MISALIGN_CHK_EN
    logic r_fault;
    assign w_misalign = (i_lsu_func3[1:0] == 2'b01 && i_lsu_alu_res[0])
                     || (i_lsu_func3[1:0] == 2'b10 && i_lsu_alu_res[1:0] != 2'b00);
    assign o_lsu_fault = r_fault;
`else
    assign w_misalign  = 1'b0;
    assign o_lsu_fault = 1'b0;
`endif

    lsu_ld_ext u_ld_ext (
        .i_rdata (i_rdata),
        .i_off   (r_addr[1:0]),
        .i_func3 (r_func3),
        .o_data  (w_ld_data)
    );

    assign w_aw_done = !r_awvalid || i_awready;
    assign w_w_done  = !r_wvalid || i_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_func3      <= '0;
            r_rd_id      <= '0;
            r_gpr_wen    <= 1'b0;
            r_wb_data    <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_bus_err    <= 1'b0;
            r_post_valid <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
            r_fault      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (i_pre_valid) begin
                    r_addr    <= i_lsu_alu_res[ADDR_W-1:0];
                    r_func3   <= i_lsu_func3;
                    r_rd_id   <= i_lsu_rd_id;
                    r_gpr_wen <= i_lsu_gpr_wen && !i_lsu_is_store;
                    r_wb_data <= i_lsu_alu_res;
                    r_wdata   <= store_data(i_lsu_func3, i_lsu_rs2);
                    r_wstrb   <= store_strb(i_lsu_func3, i_lsu_alu_res[1:0]);
                    r_bus_err <= 1'b0;
                    if ((i_lsu_is_load || i_lsu_is_store) && w_misalign) begin
                        r_gpr_wen    <= 1'b0;
                        r_post_valid <= 1'b1;
                        r_state      <= S_OUT;
`ifdef LSU_MISALIGN_CHK_EN
                        r_fault      <= 1'b1;
`endif
                    end else if (i_lsu_is_load) begin
                        r_arvalid <= 1'b1;
                        r_state   <= S_RADDR;
                    end else if (i_lsu_is_store) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_WREQ;
                    end else begin
                        r_post_valid <= 1'b1;
                        r_state      <= S_OUT;
                    end
                end
                S_RADDR: if (i_arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= S_RDATA;
                end
                S_RDATA: if (i_rvalid) begin
                    r_rready     <= 1'b0;
                    r_wb_data    <= w_ld_data;
                    r_bus_err    <= (i_rresp != RESP_OKAY);
                    r_post_valid <= 1'b1;
                    r_state      <= S_OUT;
                end
                S_WREQ: begin
                    // AW and W complete independently; wait for both before the response.
                    if (i_awready) r_awvalid <= 1'b0;
                    if (i_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: if (i_bvalid) begin
                    r_bready     <= 1'b0;
                    r_bus_err    <= (i_bresp != RESP_OKAY);
                    r_post_valid <= 1'b1;
                    r_state      <= S_OUT;
                end
                S_OUT: if (i_post_ready) begin
                    r_post_valid <= 1'b0;
                    r_state      <= S_IDLE;
`ifdef LSU_MISALIGN_CHK_EN
                    r_fault      <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_pre_ready   = (r_state == S_IDLE);
    assign o_post_valid  = r_post_valid;
    assign o_lsu_wb_data = r_wb_data;
    assign o_lsu_rd_id   = r_rd_id;
    assign o_lsu_gpr_wen = r_gpr_wen;
    assign o_lsu_bus_err = r_bus_err;
    assign o_dbg_state   = r_state;
    assign o_araddr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_arvalid     = r_arvalid;
    assign o_rready      = r_rready;
    assign o_awaddr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_awvalid     = r_awvalid;
    assign o_wdata       = r_wdata;
    assign o_wstrb       = r_wstrb;
    assign o_wvalid      = r_wvalid;
    assign o_bready      = r_bready;

endmodule

// File: tb/tb_lsu_axi.sv
// Bench for lsu_axi: directed table, hand-written reset/misalign sequences and random
// packets against an arithmetic reference model, with a delay-programmable AXI-Lite slave.
module tb_lsu_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_pre_valid, o_pre_ready, o_post_valid, i_post_ready;
    logic [31:0] i_lsu_alu_res, i_lsu_rs2, o_lsu_wb_data;
    logic        i_lsu_is_load, i_lsu_is_store, i_lsu_gpr_wen;
    logic [2:0]  i_lsu_func3, o_dbg_state;
    logic [4:0]  i_lsu_rd_id, o_lsu_rd_id;
    logic        o_lsu_gpr_wen, o_lsu_bus_err, o_lsu_fault;
    logic [31:0] o_araddr, i_rdata, o_awaddr, o_wdata;
    logic        o_arvalid, i_arready, i_rvalid, o_rready;
    logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
    logic [1:0]  i_rresp, i_bresp;
    logic [3:0]  o_wstrb;

    always #5 clk = ~clk;

    lsu_axi dut (
        .clk(clk), .rst(rst),
        .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
        .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
        .i_lsu_alu_res(i_lsu_alu_res), .i_lsu_is_load(i_lsu_is_load),
        .i_lsu_is_store(i_lsu_is_store), .i_lsu_func3(i_lsu_func3),
        .i_lsu_rs2(i_lsu_rs2), .i_lsu_rd_id(i_lsu_rd_id), .i_lsu_gpr_wen(i_lsu_gpr_wen),
        .o_lsu_wb_data(o_lsu_wb_data), .o_lsu_rd_id(o_lsu_rd_id),
        .o_lsu_gpr_wen(o_lsu_gpr_wen), .o_lsu_bus_err(o_lsu_bus_err),
        .o_lsu_fault(o_lsu_fault), .o_dbg_state(o_dbg_state),
        .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          ar_d;
        int          aw_d;
        int          w_d;
        int          r_d;
        int          b_d;
        int          hold;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] exp_wb;
        logic        exp_err;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
    } vec_t;

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        wen;
        logic        err;
        logic        fault;
        int          lat;
        logic [31:0] araddr;
        logic [31:0] awaddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ar_hs;
        int          r_hs;
        int          aw_hs;
        int          w_hs;
        int          b_hs;
        int          addr_bad;
        logic        timeout;
    } obs_t;

    typedef struct {
        logic [31:0] wb;
        logic        chk_wb;
        logic        wen;
        logic        err;
        logic        fault;
        int          lat;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rd_side;
        int          wr_side;
    } exp_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rs2,
                                input logic [31:0] rdata, input logic [1:0] resp,
                                input int ar_d, input int aw_d, input int w_d,
                                input int r_d, input int b_d, input int hold,
                                input logic [31:0] exp_wb, input logic exp_err,
                                input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
        vec_t v;
        v = '{default: 0};
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
        v.resp = resp; v.ar_d = ar_d; v.aw_d = aw_d; v.w_d = w_d; v.r_d = r_d;
        v.b_d = b_d; v.hold = hold; v.rd = 5'd1; v.wen = 1'b1;
        v.exp_wb = exp_wb; v.exp_err = exp_err; v.exp_wdata = exp_wdata; v.exp_strb = exp_strb;
        return v;
    endfunction

    // Reference model: what WBU and the bus should see, from the architectural rules.
    function automatic exp_t model(input vec_t v);
        exp_t        e;
        int          off;
        int          s;
        logic [31:0] word;
        logic        mis;
        e   = '{default: 0};
        off = int'(v.addr[1:0]);
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
        if (v.ld || v.st) begin
            if ((v.f3 == 3'b001 || v.f3 == 3'b101) && (off % 2) != 0) mis = 1'b1;
            if (v.f3 == 3'b010 && off != 0) mis = 1'b1;
        end
`endif
        e.wen    = v.wen;
        e.chk_wb = 1'b1;
        if (mis) begin
            e.wb = v.addr; e.fault = 1'b1; e.wen = 1'b0; e.lat = 1;
        end else if (v.ld) begin
            word = v.rdata >> (8 * off);
            case (v.f3)
                3'b000: begin s = int'(word % 256);   if (s >= 128)   s -= 256;   e.wb = 32'(s); end
                3'b001: begin s = int'(word % 65536); if (s >= 32768) s -= 65536; e.wb = 32'(s); end
                3'b100: e.wb = word % 256;
                3'b101: e.wb = word % 65536;
                default: e.wb = word;
            endcase
            e.err     = (v.resp != 2'b00);
            e.lat     = 3 + v.ar_d + v.r_d;
            e.rd_side = 1;
            e.waddr   = v.addr - 32'(off);
        end else if (v.st) begin
            e.wen     = 1'b0;
            e.chk_wb  = 1'b0;
            e.err     = (v.resp != 2'b00);
            e.lat     = 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d;
            e.wr_side = 1;
            e.waddr   = v.addr - 32'(off);
            case (v.f3)
                3'b000: begin e.wstrb = 4'(1 << off); e.wdata = v.rs2[7:0] * 32'h0101_0101; end
                3'b001: begin e.wstrb = 4'(3 << off); e.wdata = v.rs2[15:0] * 32'h0001_0001; end
                default: begin e.wstrb = 4'hF; e.wdata = v.rs2; end
            endcase
        end else begin
            e.wb  = v.addr;
            e.lat = 1;
        end
        return e;
    endfunction

    task automatic clear_slave();
        i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rresp = '0;
        i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = '0;
    endtask

    // Drive one packet, act as the AXI slave with per-channel delays, then release to WBU.
    task automatic do_op(input string tag, input vec_t v, output obs_t o);
        int   ar_c, r_c, aw_c, w_c, b_c;
        logic seen;
        exp_t e;
        e = model(v);
        o = '{default: 0};
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0; seen = 1'b0;
        @(negedge clk);
        chk({tag, " pre_ready_idle"}, 32'(o_pre_ready), 32'd1);
        i_pre_valid = 1'b1; i_lsu_alu_res = v.addr; i_lsu_is_load = v.ld;
        i_lsu_is_store = v.st; i_lsu_func3 = v.f3; i_lsu_rs2 = v.rs2;
        i_lsu_rd_id = v.rd; i_lsu_gpr_wen = v.wen;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            i_pre_valid = 1'b0;
            clear_slave();
            if (o_post_valid) begin
                seen = 1'b1; o.lat = c;
            end else begin
                if (o_arvalid) begin
                    ar_c++; o.araddr = o_araddr;
                    if (o_araddr != e.waddr) o.addr_bad++;
                    i_arready = (ar_c > v.ar_d);
                    if (i_arready) o.ar_hs++;
                end
                if (o_rready) begin
                    r_c++; i_rvalid = (r_c > v.r_d); i_rresp = v.resp;
                    i_rdata = i_rvalid ? v.rdata : $urandom;
                    if (i_rvalid) o.r_hs++;
                end
                if (o_awvalid) begin
                    aw_c++; o.awaddr = o_awaddr;
                    if (o_awaddr != e.waddr) o.addr_bad++;
                    i_awready = (aw_c > v.aw_d);
                    if (i_awready) o.aw_hs++;
                end
                if (o_wvalid) begin
                    w_c++; o.wdata = o_wdata; o.wstrb = o_wstrb;
                    i_wready = (w_c > v.w_d);
                    if (i_wready) o.w_hs++;
                end
                if (o_bready) begin
                    b_c++; i_bvalid = (b_c > v.b_d); i_bresp = v.resp;
                    if (i_bvalid) o.b_hs++;
                end
            end
        end
        if (!seen) begin
            chk({tag, " post_valid_timeout"}, 32'd0, 32'd1);
            rst = 1'b1; @(negedge clk); rst = 1'b0;
            o.timeout = 1'b1;
            return;
        end
        o.wb = o_lsu_wb_data; o.rd = o_lsu_rd_id; o.wen = o_lsu_gpr_wen;
        o.err = o_lsu_bus_err; o.fault = o_lsu_fault;
        chk({tag, " latency"}, 32'(o.lat), 32'(e.lat));
        chk({tag, " rd_id"}, 32'(o.rd), 32'(v.rd));
        chk({tag, " gpr_wen"}, 32'(o.wen), 32'(e.wen));
        chk({tag, " bus_err"}, 32'(o.err), 32'(e.err));
        chk({tag, " fault"}, 32'(o.fault), 32'(e.fault));
        if (e.chk_wb) chk({tag, " wb_data"}, o.wb, e.wb);
        chk({tag, " ar_hs"}, 32'(o.ar_hs), 32'(e.rd_side));
        chk({tag, " r_hs"}, 32'(o.r_hs), 32'(e.rd_side));
        chk({tag, " aw_hs"}, 32'(o.aw_hs), 32'(e.wr_side));
        chk({tag, " w_hs"}, 32'(o.w_hs), 32'(e.wr_side));
        chk({tag, " b_hs"}, 32'(o.b_hs), 32'(e.wr_side));
        chk({tag, " addr_align"}, 32'(o.addr_bad), 32'd0);
        if (e.wr_side != 0) begin
            chk({tag, " wdata"}, o.wdata, e.wdata);
            chk({tag, " wstrb"}, 32'(o.wstrb), 32'(e.wstrb));
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({tag, " hold_post_valid"}, 32'(o_post_valid), 32'd1);
            chk({tag, " hold_pre_ready"}, 32'(o_pre_ready), 32'd0);
            chk({tag, " hold_bus_err"}, 32'(o_lsu_bus_err), 32'(e.err));
            if (e.chk_wb) chk({tag, " hold_wb"}, o_lsu_wb_data, e.wb);
        end
        i_post_ready = 1'b1;
        @(negedge clk);
        i_post_ready = 1'b0;
        chk({tag, " release_post_valid"}, 32'(o_post_valid), 32'd0);
        chk({tag, " release_pre_ready"}, 32'(o_pre_ready), 32'd1);
    endtask

    initial begin
        obs_t        o;
        vec_t        v;
        int          k;
        logic [2:0]  ld_f3[5];
        logic [2:0]  st_f3[3];
        logic        got;

        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3 = '{3'b000, 3'b001, 3'b010};

        //           ld st f3 addr          rs2           rdata         resp  ar aw w r b hold  wb            err wdata         strb
        tbl[0] = mk(0, 0, 0, 32'h0000_1234, 32'h0,        32'h0,        2'b00, 0, 0, 0, 0, 0, 0, 32'h0000_1234, 0, 32'h0,        4'h0);
        tbl[1] = mk(1, 0, 0, 32'h8000_0003, 32'h0,        32'h8012_3456, 2'b00, 3, 0, 0, 0, 0, 1, 32'hFFFF_FF80, 0, 32'h0,        4'h0);
        tbl[2] = mk(1, 0, 4, 32'h8000_0003, 32'h0,        32'h8012_3456, 2'b00, 3, 0, 0, 0, 0, 0, 32'h0000_0080, 0, 32'h0,        4'h0);
        tbl[3] = mk(0, 1, 1, 32'h0000_0102, 32'h0000_ABCD, 32'h0,        2'b00, 0, 0, 2, 0, 0, 0, 32'h0,        0, 32'hABCD_ABCD, 4'b1100);
        tbl[4] = mk(0, 1, 2, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,        2'b10, 0, 1, 0, 0, 1, 4, 32'h0,        1, 32'hCAFE_F00D, 4'b1111);
        tbl[5] = mk(1, 0, 1, 32'h0000_0002, 32'h0,        32'h8001_1234, 2'b00, 1, 0, 0, 1, 0, 0, 32'hFFFF_8001, 0, 32'h0,        4'h0);
        tbl[6] = mk(1, 0, 5, 32'h0000_0100, 32'h0,        32'h1234_ABCD, 2'b00, 0, 0, 0, 2, 0, 0, 32'h0000_ABCD, 0, 32'h0,        4'h0);
        tbl[7] = mk(1, 0, 2, 32'h0000_0020, 32'h0,        32'hDEAD_BEEF, 2'b11, 0, 0, 0, 2, 0, 2, 32'hDEAD_BEEF, 1, 32'h0,        4'h0);
        tbl[8] = mk(0, 1, 0, 32'h0000_0041, 32'h1234_5678, 32'h0,        2'b00, 0, 2, 0, 0, 1, 0, 32'h0,        0, 32'h7878_7878, 4'b0010);

        // Clock/reset
        rst = 1'b1; i_pre_valid = 1'b0; i_post_ready = 1'b0;
        i_lsu_alu_res = '0; i_lsu_is_load = 1'b0; i_lsu_is_store = 1'b0; i_lsu_func3 = '0;
        i_lsu_rs2 = '0; i_lsu_rd_id = '0; i_lsu_gpr_wen = 1'b0;
        clear_slave();
        repeat (3) @(negedge clk);
        chk("reset pre_ready", 32'(o_pre_ready), 32'd1);
        chk("reset post_valid", 32'(o_post_valid), 32'd0);
        chk("reset axi_valids", 32'({o_arvalid, o_awvalid, o_wvalid}), 32'd0);
        chk("reset axi_readies", 32'({o_rready, o_bready}), 32'd0);
        chk("reset err_fault", 32'({o_lsu_bus_err, o_lsu_fault}), 32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            tbl[i].rd = 5'(i + 3);
            do_op($sformatf("tbl%0d", i), tbl[i], o);
            if (!o.timeout) begin
                if (!tbl[i].st) chk($sformatf("tbl%0d exp_wb", i), o.wb, tbl[i].exp_wb);
                chk($sformatf("tbl%0d exp_err", i), 32'(o.err), 32'(tbl[i].exp_err));
                if (tbl[i].st) begin
                    chk($sformatf("tbl%0d exp_wdata", i), o.wdata, tbl[i].exp_wdata);
                    chk($sformatf("tbl%0d exp_strb", i), 32'(o.wstrb), 32'(tbl[i].exp_strb));
                end
            end
        end

        // Reset in the middle of a read data wait, then a clean load
        @(negedge clk);
        i_pre_valid = 1'b1; i_lsu_alu_res = 32'h40; i_lsu_is_load = 1'b1;
        i_lsu_is_store = 1'b0; i_lsu_func3 = 3'b010; i_lsu_gpr_wen = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            i_pre_valid = 1'b0;
            i_arready = o_arvalid;
            if (o_rready) got = 1'b1;
        end
        chk("midrst reached_rdata", 32'(got), 32'd1);
        clear_slave();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst pre_ready", 32'(o_pre_ready), 32'd1);
        chk("midrst valids", 32'({o_arvalid, o_awvalid, o_wvalid, o_post_valid}), 32'd0);
        chk("midrst readies", 32'({o_rready, o_bready}), 32'd0);
        chk("midrst bus_err", 32'(o_lsu_bus_err), 32'd0);
        v = mk(1, 0, 2, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 2'b00, 1, 0, 0, 1, 0, 0,
               32'h0BAD_F00D, 0, 32'h0, 4'h0);
        do_op("post_rst_load", v, o);
        chk("post_rst_load wb", o.wb, 32'h0BAD_F00D);

        // Misaligned word load
        v = mk(1, 0, 2, 32'h0000_0002, 32'h0, 32'h1122_3344, 2'b00, 0, 0, 0, 0, 0, 1,
               32'h0, 0, 32'h0, 4'h0);
        do_op("misalign_lw", v, o);
`ifdef LSU_MISALIGN_CHK_EN
        chk("misalign_lw fault", 32'(o.fault), 32'd1);
        chk("misalign_lw no_ar", 32'(o.ar_hs), 32'd0);
        chk("misalign_lw wb_addr", o.wb, 32'h0000_0002);
`else
        chk("misalign_lw araddr", o.araddr, 32'h0);
        chk("misalign_lw wb", o.wb, 32'h0000_1122);
`endif

        // Random packets against the model
        for (int n = 0; n < 40; n++) begin
            v = '{default: 0};
            k = $urandom_range(0, 2);
            v.ld = (k == 1); v.st = (k == 2);
            v.f3 = v.ld ? ld_f3[$urandom_range(0, 4)]
                 : v.st ? st_f3[$urandom_range(0, 2)] : 3'($urandom_range(0, 7));
            v.addr = $urandom; v.rs2 = $urandom; v.rdata = $urandom;
            v.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.ar_d = $urandom_range(0, 3); v.aw_d = $urandom_range(0, 3);
            v.w_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 3);
            v.b_d = $urandom_range(0, 3); v.hold = $urandom_range(0, 2);
            v.rd = 5'($urandom_range(0, 31)); v.wen = 1'($urandom_range(0, 1));
            do_op($sformatf("rand%0d", n), v, o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
